// File: rtl/icache_ctrl.sv
// icache_ctrl: direct-mapped I-cache + block refill FSM (IDLE/WAIT/REFILL)
// Ports: IF fetch (addr/req/flush -> instr/valid/FREEZE), block mem, stats
module icache_ctrl #(
  parameter int NUM_LINES = 32,
  parameter int IDXW      = 5
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [31:0]  Instr_address_2IM,
  input  logic         fetch_req,
  input  logic         flush,
  output logic [31:0]  Instr1_fIM,
  output logic         instr_valid,
  output logic         FREEZE,
  output logic         iBlkRead,
  output logic [31:0]  iblk_addr,
  input  logic [255:0] block_read_fIM,
  input  logic         iblk_ready,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
);

  localparam int TAGW = 27 - IDXW;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_REFILL
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [255:0]    r_data [NUM_LINES];
  logic [TAGW-1:0] r_tag  [NUM_LINES];
  logic [NUM_LINES-1:0] r_valid;

  logic [255:0] r_line;
  logic [31:0]  r_addr;
  logic [31:0]  r_instr;
  logic [31:0]  r_hit_cnt;
  logic [31:0]  r_miss_cnt;
  logic         r_discard;

  logic [2:0]      w_word;
  logic [IDXW-1:0] w_idx;
  logic [TAGW-1:0] w_tag;
  logic [IDXW-1:0] w_fill_idx;
  logic [TAGW-1:0] w_fill_tag;
  logic [31:0]     w_rd_word;
  logic            w_idle;
  logic            w_hit;
  logic            w_miss;
  logic            w_fill_we;
  logic            w_unused;

  assign w_word     = Instr_address_2IM[4:2];
  assign w_idx      = Instr_address_2IM[5+IDXW-1:5];
  assign w_tag      = Instr_address_2IM[31:5+IDXW];
  assign w_fill_idx = r_addr[5+IDXW-1:5];
  assign w_fill_tag = r_addr[31:5+IDXW];
  assign w_unused   = ^Instr_address_2IM[1:0];

  assign w_idle    = (r_state == S_IDLE);
  assign w_rd_word = r_data[w_idx][{w_word, 5'b0} +: 32];
  assign w_hit     = w_idle & fetch_req & r_valid[w_idx]
                   & (r_tag[w_idx] == w_tag);
  assign w_miss    = w_idle & fetch_req & ~w_hit;
  // flush has priority over installing the line
  assign w_fill_we = (r_state == S_REFILL) & ~r_discard & ~flush;

  // state register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // next state
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (w_miss) w_next = S_WAIT;
      S_WAIT:   if (iblk_ready) w_next = S_REFILL;
      S_REFILL: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // outputs; FREEZE is forced low while reset is asserted
  always_comb begin
    instr_valid = w_hit;
    Instr1_fIM  = w_hit ? w_rd_word : r_instr;
    iBlkRead    = (r_state == S_WAIT);
    FREEZE      = RESET & (w_miss | ~w_idle);
    iblk_addr   = r_addr;
    hit_count   = r_hit_cnt;
    miss_count  = r_miss_cnt;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_valid    <= '0;
      r_addr     <= '0;
      r_instr    <= '0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
      r_discard  <= 1'b0;
      r_line     <= '0;
    end else begin
      if (w_hit) begin
        r_instr <= w_rd_word;
        if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + 32'd1;
      end
      if (w_miss) begin
        r_addr <= {Instr_address_2IM[31:5], 5'b0};
        if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 32'd1;
      end
      if ((r_state == S_WAIT) && iblk_ready) r_line <= block_read_fIM;
      // a flush during WAIT poisons the in-flight line
      if ((r_state == S_WAIT) && flush) r_discard <= 1'b1;
      else if (r_state == S_REFILL)     r_discard <= 1'b0;
      if (flush)          r_valid             <= '0;
      else if (w_fill_we) r_valid[w_fill_idx] <= 1'b1;
    end
  end

  // arrays carry no reset; valid bits guard them
  always_ff @(posedge CLK) begin
    if (w_fill_we) begin
      r_data[w_fill_idx] <= r_line;
      r_tag[w_fill_idx]  <= w_fill_tag;
    end
  end

endmodule

// File: tb/tb_icache_ctrl.sv
// tb_icache_ctrl: randomized bench with a line-level cache model
// Memory model answers block reads; scenarios check fetch results/stats
module tb_icache_ctrl;

  localparam int NL = 32;

  logic         CLK = 1'b0;
  logic         RESET = 1'b0;
  logic [31:0]  Instr_address_2IM = '0;
  logic         fetch_req = 1'b0;
  logic         flush = 1'b0;
  logic [31:0]  Instr1_fIM;
  logic         instr_valid;
  logic         FREEZE;
  logic         iBlkRead;
  logic [31:0]  iblk_addr;
  logic [255:0] block_read_fIM = '0;
  logic         iblk_ready = 1'b0;
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;

  icache_ctrl #(.NUM_LINES(NL), .IDXW(5)) dut (
    .CLK(CLK), .RESET(RESET),
    .Instr_address_2IM(Instr_address_2IM),
    .fetch_req(fetch_req), .flush(flush),
    .Instr1_fIM(Instr1_fIM), .instr_valid(instr_valid),
    .FREEZE(FREEZE), .iBlkRead(iBlkRead), .iblk_addr(iblk_addr),
    .block_read_fIM(block_read_fIM), .iblk_ready(iblk_ready),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_pass = 0;

  bit          m_valid [NL];
  logic [21:0] m_tag   [NL];
  logic [31:0] m_hits;
  logic [31:0] m_miss;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0040_0008) return 32'h8C01_0004;
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  function automatic logic [255:0] mem_line(input logic [31:0] a);
    logic [255:0] l;
    logic [31:0] b;
    b = {a[31:5], 5'b0};
    for (int w = 0; w < 8; w++) l[32*w +: 32] = mem_word(b + 32'(4*w));
    return l;
  endfunction

  function automatic logic [31:0] sat(input logic [31:0] x);
    return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
    m_hits = '0;
    m_miss = '0;
  endtask

  // A fetch retries until it hits; each miss reads one line.
  task automatic model_fetch(input logic [31:0] a, input bit fw,
                             output int nmiss);
    int idx;
    bit fl;
    idx = int'(a[9:5]);
    fl = fw;
    nmiss = 0;
    for (int it = 0; it < 3; it++) begin
      if (m_valid[idx] && m_tag[idx] == a[31:10]) begin
        m_hits = sat(m_hits);
        break;
      end
      m_miss = sat(m_miss);
      nmiss++;
      if (fl) begin
        for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
        fl = 1'b0;
      end else begin
        m_valid[idx] = 1'b1;
        m_tag[idx] = a[31:10];
      end
    end
  endtask

  // Drive one fetch, play memory with d WAIT cycles, observe the result.
  task automatic run_fetch(input logic [31:0] a, input int d, input bit fw,
                           output logic [31:0] instr, output int fz,
                           output int rd, output logic [31:0] rda,
                           output bit tmo);
    bit prev, fpend;
    int wc;
    instr = '0; fz = 0; rd = 0; rda = '0; tmo = 1'b1;
    prev = 1'b0; fpend = fw; wc = 0;
    @(negedge CLK);
    fetch_req = 1'b1; Instr_address_2IM = a;
    flush = 1'b0; iblk_ready = 1'b0;
    #1;
    for (int c = 0; c < 80; c++) begin
      if (c > 0) begin
        @(negedge CLK);
        iblk_ready = 1'b0; flush = 1'b0;
        #1;
      end
      if (instr_valid) begin
        instr = Instr1_fIM;
        tmo = 1'b0;
        break;
      end
      if (FREEZE) fz++;
      if (iBlkRead) begin
        if (!prev) begin
          rd++; rda = iblk_addr; wc = 0;
          if (fpend) begin flush = 1'b1; fpend = 1'b0; end
        end
        wc++;
        if (wc == d) begin
          iblk_ready = 1'b1;
          block_read_fIM = mem_line(iblk_addr);
        end
      end
      prev = iBlkRead;
    end
    @(posedge CLK); #1;
    fetch_req = 1'b0;
  endtask

  logic [31:0] g_instr, g_rda;
  int g_fz, g_rd, g_nm;
  bit g_tmo;

  task automatic test_reset();
    RESET = 1'b0; fetch_req = 1'b0; flush = 1'b0; iblk_ready = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    model_reset();
    n_chk++; if (FREEZE !== 1'b0) $display("FAIL rst_freeze got %b want 0", FREEZE); else n_pass++;
    n_chk++; if (iBlkRead !== 1'b0) $display("FAIL rst_blkread got %b want 0", iBlkRead); else n_pass++;
    n_chk++; if (instr_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", instr_valid); else n_pass++;
    n_chk++; if (Instr1_fIM !== 32'h0) $display("FAIL rst_instr got %h want 0", Instr1_fIM); else n_pass++;
    n_chk++; if (iblk_addr !== 32'h0) $display("FAIL rst_addr got %h want 0", iblk_addr); else n_pass++;
    n_chk++; if (hit_count !== m_hits || miss_count !== m_miss)
      $display("FAIL rst_counts got %h/%h want %h/%h", hit_count, miss_count, m_hits, m_miss);
    else n_pass++;
    @(negedge CLK); RESET = 1'b1;
  endtask

  task automatic test_cold_miss();
    run_fetch(32'h0040_0008, 3, 1'b0, g_instr, g_fz, g_rd, g_rda, g_tmo);
    model_fetch(32'h0040_0008, 1'b0, g_nm);
    n_chk++; if (g_tmo !== 1'b0) $display("FAIL cold_timeout got %b want 0", g_tmo); else n_pass++;
    n_chk++; if (g_rda !== 32'h0040_0000) $display("FAIL cold_blkaddr got %h want 00400000", g_rda); else n_pass++;
    n_chk++; if (g_rd !== g_nm) $display("FAIL cold_reads got %0d want %0d", g_rd, g_nm); else n_pass++;
    n_chk++; if (g_fz !== 5) $display("FAIL cold_freeze got %0d want 5", g_fz); else n_pass++;
    n_chk++; if (g_instr !== 32'h8C01_0004) $display("FAIL cold_instr got %h want 8c010004", g_instr); else n_pass++;
    n_chk++; if (hit_count !== m_hits || miss_count !== m_miss)
      $display("FAIL cold_counts got %h/%h want %h/%h", hit_count, miss_count, m_hits, m_miss);
    else n_pass++;
  endtask

  task automatic test_seq_hits();
    logic [31:0] a;
    for (int w = 0; w < 8; w++) begin
      a = 32'h0040_0000 + 32'(4*w);
      run_fetch(a, 2, 1'b0, g_instr, g_fz, g_rd, g_rda, g_tmo);
      model_fetch(a, 1'b0, g_nm);
      n_chk++; if (g_instr !== mem_word(a)) $display("FAIL seq_instr[%0d] got %h want %h", w, g_instr, mem_word(a)); else n_pass++;
      n_chk++; if (g_fz !== 0) $display("FAIL seq_freeze[%0d] got %0d want 0", w, g_fz); else n_pass++;
      n_chk++; if (g_rd !== g_nm) $display("FAIL seq_reads[%0d] got %0d want %0d", w, g_rd, g_nm); else n_pass++;
    end
    #1;
    n_chk++; if (instr_valid !== 1'b0) $display("FAIL seq_idle_valid got %b want 0", instr_valid); else n_pass++;
    n_chk++; if (Instr1_fIM !== mem_word(32'h0040_001C)) $display("FAIL seq_hold got %h want %h", Instr1_fIM, mem_word(32'h0040_001C)); else n_pass++;
    n_chk++; if (hit_count !== m_hits) $display("FAIL seq_hits got %h want %h", hit_count, m_hits); else n_pass++;
  endtask

  task automatic test_conflict();
    logic [31:0] al [2];
    logic [31:0] m0;
    int d;
    al[0] = 32'h0040_0404; al[1] = 32'h0040_0000;
    m0 = m_miss;
    for (int i = 0; i < 2; i++) begin
      d = $urandom_range(1, 4);
      run_fetch(al[i], d, 1'b0, g_instr, g_fz, g_rd, g_rda, g_tmo);
      model_fetch(al[i], 1'b0, g_nm);
      n_chk++; if (g_rd !== g_nm) $display("FAIL conf_reads[%0d] got %0d want %0d", i, g_rd, g_nm); else n_pass++;
      n_chk++; if (g_rda !== {al[i][31:5], 5'b0}) $display("FAIL conf_addr[%0d] got %h want %h", i, g_rda, {al[i][31:5], 5'b0}); else n_pass++;
      n_chk++; if (g_fz !== g_nm * (d + 2)) $display("FAIL conf_freeze[%0d] got %0d want %0d", i, g_fz, g_nm * (d + 2)); else n_pass++;
      n_chk++; if (g_instr !== mem_word(al[i])) $display("FAIL conf_instr[%0d] got %h want %h", i, g_instr, mem_word(al[i])); else n_pass++;
    end
    n_chk++; if (miss_count !== m0 + 32'd2) $display("FAIL conf_misses got %h want %h", miss_count, m0 + 32'd2); else n_pass++;
  endtask

  task automatic test_flush_wait();
    run_fetch(32'h0040_0020, 2, 1'b1, g_instr, g_fz, g_rd, g_rda, g_tmo);
    model_fetch(32'h0040_0020, 1'b1, g_nm);
    n_chk++; if (g_tmo !== 1'b0) $display("FAIL fw_timeout got %b want 0", g_tmo); else n_pass++;
    n_chk++; if (g_rd !== 2) $display("FAIL fw_reads got %0d want 2", g_rd); else n_pass++;
    n_chk++; if (g_rda !== 32'h0040_0020) $display("FAIL fw_addr got %h want 00400020", g_rda); else n_pass++;
    n_chk++; if (g_fz !== 8) $display("FAIL fw_freeze got %0d want 8", g_fz); else n_pass++;
    n_chk++; if (g_instr !== mem_word(32'h0040_0020)) $display("FAIL fw_instr got %h want %h", g_instr, mem_word(32'h0040_0020)); else n_pass++;
    n_chk++; if (hit_count !== m_hits || miss_count !== m_miss)
      $display("FAIL fw_counts got %h/%h want %h/%h", hit_count, miss_count, m_hits, m_miss);
    else n_pass++;
  endtask

  task automatic test_flush_idle();
    @(negedge CLK);
    fetch_req = 1'b1; Instr_address_2IM = 32'h0040_0024; flush = 1'b1;
    #1;
    n_chk++; if (instr_valid !== 1'b1) $display("FAIL fi_prehit got %b want 1", instr_valid); else n_pass++;
    n_chk++; if (Instr1_fIM !== mem_word(32'h0040_0024)) $display("FAIL fi_instr got %h want %h", Instr1_fIM, mem_word(32'h0040_0024)); else n_pass++;
    @(posedge CLK); #1;
    fetch_req = 1'b0; flush = 1'b0;
    model_fetch(32'h0040_0024, 1'b0, g_nm);
    for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
    run_fetch(32'h0040_0024, 1, 1'b0, g_instr, g_fz, g_rd, g_rda, g_tmo);
    model_fetch(32'h0040_0024, 1'b0, g_nm);
    n_chk++; if (g_rd !== 1 || g_nm !== 1) $display("FAIL fi_refetch_miss got %0d want 1", g_rd); else n_pass++;
    n_chk++; if (hit_count !== m_hits || miss_count !== m_miss)
      $display("FAIL fi_counts got %h/%h want %h/%h", hit_count, miss_count, m_hits, m_miss);
    else n_pass++;
  endtask

  task automatic test_reset_midfill();
    @(negedge CLK);
    fetch_req = 1'b1; Instr_address_2IM = 32'h0040_0040;
    #1;
    for (int c = 0; c < 10 && !iBlkRead; c++) begin
      @(negedge CLK); #1;
    end
    n_chk++; if (iBlkRead !== 1'b1) $display("FAIL rm_read_start got %b want 1", iBlkRead); else n_pass++;
    #2;
    RESET = 1'b0;
    #1;
    n_chk++; if (iBlkRead !== 1'b0) $display("FAIL rm_async_read got %b want 0", iBlkRead); else n_pass++;
    n_chk++; if (FREEZE !== 1'b0) $display("FAIL rm_async_freeze got %b want 0", FREEZE); else n_pass++;
    @(negedge CLK);
    fetch_req = 1'b0; RESET = 1'b1;
    model_reset();
    @(negedge CLK);
    iblk_ready = 1'b1; block_read_fIM = mem_line(32'h0040_0040);
    @(negedge CLK);
    iblk_ready = 1'b0;
    #1;
    n_chk++; if (iBlkRead !== 1'b0 || FREEZE !== 1'b0)
      $display("FAIL rm_late_ready got %b%b want 00", iBlkRead, FREEZE);
    else n_pass++;
    run_fetch(32'h0040_0000, 2, 1'b0, g_instr, g_fz, g_rd, g_rda, g_tmo);
    model_fetch(32'h0040_0000, 1'b0, g_nm);
    n_chk++; if (g_rd !== 1) $display("FAIL rm_cold_again got %0d want 1", g_rd); else n_pass++;
    n_chk++; if (hit_count !== m_hits || miss_count !== m_miss)
      $display("FAIL rm_counts got %h/%h want %h/%h", hit_count, miss_count, m_hits, m_miss);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [21:0] tags [4];
    logic [31:0] a;
    int d;
    bit fw;
    tags[0] = 22'h001000; tags[1] = 22'h001001;
    tags[2] = 22'h2A5F31; tags[3] = 22'h0C0FFE;
    for (int i = 0; i < 40; i++) begin
      a = {tags[$urandom_range(0, 3)], 5'($urandom_range(0, 3)),
           3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      d = $urandom_range(1, 4);
      fw = ($urandom_range(0, 7) == 0);
      run_fetch(a, d, fw, g_instr, g_fz, g_rd, g_rda, g_tmo);
      model_fetch(a, fw, g_nm);
      n_chk++; if (g_instr !== mem_word({a[31:2], 2'b00}) || g_tmo)
        $display("FAIL rnd_instr[%0d] a=%h got %h want %h", i, a, g_instr, mem_word({a[31:2], 2'b00}));
      else n_pass++;
      n_chk++; if (g_rd !== g_nm) $display("FAIL rnd_reads[%0d] got %0d want %0d", i, g_rd, g_nm); else n_pass++;
      n_chk++; if (g_fz !== g_nm * (d + 2)) $display("FAIL rnd_freeze[%0d] got %0d want %0d", i, g_fz, g_nm * (d + 2)); else n_pass++;
    end
    n_chk++; if (hit_count !== m_hits || miss_count !== m_miss)
      $display("FAIL rnd_counts got %h/%h want %h/%h", hit_count, miss_count, m_hits, m_miss);
    else n_pass++;
  endtask

  task automatic test_saturation();
    run_fetch(32'h0040_0000, 1, 1'b0, g_instr, g_fz, g_rd, g_rda, g_tmo);
    model_fetch(32'h0040_0000, 1'b0, g_nm);
    @(negedge CLK);
    force dut.r_hit_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.r_hit_cnt;
    m_hits = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) begin
      run_fetch(32'h0040_0000 + 32'(4*i), 1, 1'b0, g_instr, g_fz, g_rd, g_rda, g_tmo);
      model_fetch(32'h0040_0000 + 32'(4*i), 1'b0, g_nm);
      n_chk++; if (hit_count !== m_hits) $display("FAIL sat_hits[%0d] got %h want %h", i, hit_count, m_hits); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_seq_hits();
    test_conflict();
    test_flush_wait();
    test_flush_idle();
    test_reset_midfill();
    test_random();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired after %0d checks", n_chk);
    $fatal(1);
  end

endmodule
